// File: rtl/sb_tx_arbiter.sv
// Sideband TX arbiter: holds one LTSM and one RDI message, picks a winner,
// drives the encoder and tracks encoder-valid / tx-done / timeout per message.
module sb_tx_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_RDI_STREAK = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ltsm_req,
    input  logic [3:0]  i_ltsm_state,
    input  logic [3:0]  i_ltsm_sub_state,
    input  logic [3:0]  i_ltsm_msg_no,
    input  logic        i_ltsm_data_valid,
    input  logic [15:0] i_ltsm_data,
    output logic        o_ltsm_ready,
    output logic        o_ltsm_ack,
    input  logic        i_rdi_req,
    output logic        o_rdi_ready,
    output logic        o_rdi_ack,
    output logic        o_msg_valid,
    output logic        o_data_valid,
    output logic        o_rdi_msg,
    output logic [3:0]  o_state,
    output logic [3:0]  o_sub_state,
    output logic [3:0]  o_msg_no,
    output logic [15:0] o_data_bus,
    input  logic        i_enc_d_valid,
    input  logic        i_tx_done,
    output logic        o_busy,
    output logic        o_drop,
    output logic        o_timeout
);

    localparam logic [7:0] STREAK_MAX = 8'(MAX_RDI_STREAK);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ENC, WAIT_TX} state_t;

    state_t      fsm;
    logic        ltsm_full;
    logic        rdi_full;
    logic [3:0]  slot_state;
    logic [3:0]  slot_sub;
    logic [3:0]  slot_no;
    logic        slot_dv;
    logic [15:0] slot_data;
    logic        win_ltsm;
    logic [7:0]  streak;
    logic [7:0]  cnt;

    logic ltsm_take;
    logic rdi_take;
    logic ltsm_pick;
    logic release_slot;

    assign o_ltsm_ready = !ltsm_full;
    assign o_rdi_ready  = !rdi_full;
    assign o_busy       = (fsm != IDLE);

    assign ltsm_take = i_ltsm_req && !ltsm_full;
    assign rdi_take  = i_rdi_req && !rdi_full;
    assign ltsm_pick = ltsm_full && (!rdi_full || streak >= STREAK_MAX);

    // Winner's slot is freed on drop, done or timeout
    assign release_slot =
        (fsm == WAIT_ENC && !i_enc_d_valid) ||
        (fsm == WAIT_TX && (i_tx_done || cnt == TMO_LAST));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ltsm_full  <= 1'b0;
            rdi_full   <= 1'b0;
            slot_state <= '0;
            slot_sub   <= '0;
            slot_no    <= '0;
            slot_dv    <= 1'b0;
            slot_data  <= '0;
        end else begin
            if (ltsm_take) begin
                ltsm_full  <= 1'b1;
                slot_state <= i_ltsm_state;
                slot_sub   <= i_ltsm_sub_state;
                slot_no    <= i_ltsm_msg_no;
                slot_dv    <= i_ltsm_data_valid;
                slot_data  <= i_ltsm_data;
            end else if (release_slot && win_ltsm) begin
                ltsm_full <= 1'b0;
            end
            if (rdi_take) begin
                rdi_full <= 1'b1;
            end else if (release_slot && !win_ltsm) begin
                rdi_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fsm          <= IDLE;
            win_ltsm     <= 1'b0;
            streak       <= '0;
            cnt          <= '0;
            o_msg_valid  <= 1'b0;
            o_rdi_msg    <= 1'b0;
            o_data_valid <= 1'b0;
            o_state      <= '0;
            o_sub_state  <= '0;
            o_msg_no     <= '0;
            o_data_bus   <= '0;
            o_ltsm_ack   <= 1'b0;
            o_rdi_ack    <= 1'b0;
            o_drop       <= 1'b0;
            o_timeout    <= 1'b0;
        end else begin
            o_msg_valid  <= 1'b0;
            o_rdi_msg    <= 1'b0;
            o_data_valid <= 1'b0;
            o_ltsm_ack   <= 1'b0;
            o_rdi_ack    <= 1'b0;
            o_drop       <= 1'b0;
            o_timeout    <= 1'b0;
            unique case (fsm)
                IDLE: begin
                    if (ltsm_full || rdi_full) begin
                        fsm         <= ISSUE;
                        o_msg_valid <= 1'b1;
                        win_ltsm    <= ltsm_pick;
                        if (ltsm_pick) begin
                            streak       <= '0;
                            o_data_valid <= slot_dv;
                            o_state      <= slot_state;
                            o_sub_state  <= slot_sub;
                            o_msg_no     <= slot_no;
                            o_data_bus   <= slot_data;
                        end else begin
                            if (streak < STREAK_MAX) begin
                                streak <= streak + 8'd1;
                            end
                            o_rdi_msg   <= 1'b1;
                            o_state     <= '0;
                            o_sub_state <= '0;
                            o_msg_no    <= '0;
                            o_data_bus  <= '0;
                        end
                    end
                end
                ISSUE: begin
                    fsm <= WAIT_ENC;
                end
                WAIT_ENC: begin
                    if (i_enc_d_valid) begin
                        fsm <= WAIT_TX;
                        cnt <= '0;
                    end else begin
                        fsm        <= IDLE;
                        o_drop     <= 1'b1;
                        o_ltsm_ack <= win_ltsm;
                        o_rdi_ack  <= !win_ltsm;
                    end
                end
                WAIT_TX: begin
                    if (i_tx_done) begin
                        fsm        <= IDLE;
                        o_ltsm_ack <= win_ltsm;
                        o_rdi_ack  <= !win_ltsm;
                    end else if (cnt == TMO_LAST) begin
                        fsm       <= IDLE;
                        o_timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sb_tx_arbiter.sv
// Directed bench for sb_tx_arbiter: single issue, priority, streak,
// drop, timeout and mid-transaction reset.
module tb_sb_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_ltsm_req = 1'b0;
    logic [3:0]  i_ltsm_state = '0;
    logic [3:0]  i_ltsm_sub_state = '0;
    logic [3:0]  i_ltsm_msg_no = '0;
    logic        i_ltsm_data_valid = 1'b0;
    logic [15:0] i_ltsm_data = '0;
    logic        i_rdi_req = 1'b0;
    logic        i_enc_d_valid = 1'b0;
    logic        i_tx_done = 1'b0;
    logic        o_ltsm_ready;
    logic        o_ltsm_ack;
    logic        o_rdi_ready;
    logic        o_rdi_ack;
    logic        o_msg_valid;
    logic        o_data_valid;
    logic        o_rdi_msg;
    logic [3:0]  o_state;
    logic [3:0]  o_sub_state;
    logic [3:0]  o_msg_no;
    logic [15:0] o_data_bus;
    logic        o_busy;
    logic        o_drop;
    logic        o_timeout;

    int checks = 0;
    int failures = 0;
    int busy_cnt = 0;

    always #5 clk = ~clk;

    sb_tx_arbiter #(
        .TIMEOUT_CYCLES(8),
        .MAX_RDI_STREAK(2)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_ltsm_req(i_ltsm_req),
        .i_ltsm_state(i_ltsm_state),
        .i_ltsm_sub_state(i_ltsm_sub_state),
        .i_ltsm_msg_no(i_ltsm_msg_no),
        .i_ltsm_data_valid(i_ltsm_data_valid),
        .i_ltsm_data(i_ltsm_data),
        .o_ltsm_ready(o_ltsm_ready),
        .o_ltsm_ack(o_ltsm_ack),
        .i_rdi_req(i_rdi_req),
        .o_rdi_ready(o_rdi_ready),
        .o_rdi_ack(o_rdi_ack),
        .o_msg_valid(o_msg_valid),
        .o_data_valid(o_data_valid),
        .o_rdi_msg(o_rdi_msg),
        .o_state(o_state),
        .o_sub_state(o_sub_state),
        .o_msg_no(o_msg_no),
        .o_data_bus(o_data_bus),
        .i_enc_d_valid(i_enc_d_valid),
        .i_tx_done(i_tx_done),
        .o_busy(o_busy),
        .o_drop(o_drop),
        .o_timeout(o_timeout)
    );

    task automatic step();
        @(posedge clk);
        #1;
        if (o_busy) busy_cnt++;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ltsm(input logic [3:0] st, input logic [3:0] sub,
                        input logic [3:0] no, input logic dv,
                        input logic [15:0] d);
        i_ltsm_req        = 1'b1;
        i_ltsm_state      = st;
        i_ltsm_sub_state  = sub;
        i_ltsm_msg_no     = no;
        i_ltsm_data_valid = dv;
        i_ltsm_data       = d;
    endtask

    logic grants [0:7];
    int   n;
    int   since;
    int   guard;
    logic p_iss;
    logic p_enc;
    logic ack_seen;

    initial begin
        #2 rst_n = 1'b0;
        step();
        step();
        // reset values
        chk("rst_busy", 16'(o_busy), 16'd0);
        chk("rst_ltsm_ready", 16'(o_ltsm_ready), 16'd1);
        chk("rst_rdi_ready", 16'(o_rdi_ready), 16'd1);
        chk("rst_msg_valid", 16'(o_msg_valid), 16'd0);
        chk("rst_data_bus", o_data_bus, 16'd0);
        rst_n = 1'b1;

        // single LTSM message
        ltsm(4'd3, 4'd0, 4'd1, 1'b1, 16'h07FF);
        step();
        i_ltsm_req = 1'b0;
        chk("s1_slot_full", 16'(o_ltsm_ready), 16'd0);
        chk("s1_idle", 16'(o_busy), 16'd0);
        busy_cnt = 0;
        step();
        chk("s1_msg_valid", 16'(o_msg_valid), 16'd1);
        chk("s1_rdi_msg", 16'(o_rdi_msg), 16'd0);
        chk("s1_data_valid", 16'(o_data_valid), 16'd1);
        chk("s1_state", 16'(o_state), 16'd3);
        chk("s1_sub", 16'(o_sub_state), 16'd0);
        chk("s1_msg_no", 16'(o_msg_no), 16'd1);
        chk("s1_data", o_data_bus, 16'h07FF);
        i_enc_d_valid = 1'b1;
        step();
        chk("s1_issue_one", 16'(o_msg_valid), 16'd0);
        chk("s1_hold_data", o_data_bus, 16'h07FF);
        step();
        i_enc_d_valid = 1'b0;
        step();
        step();
        step();
        i_tx_done = 1'b1;
        chk("s1_no_early_ack", 16'(o_ltsm_ack), 16'd0);
        step();
        i_tx_done = 1'b0;
        chk("s1_ack", 16'(o_ltsm_ack), 16'd1);
        chk("s1_ready", 16'(o_ltsm_ready), 16'd1);
        chk("s1_busy_cycles", 16'(busy_cnt), 16'd6);
        step();
        chk("s1_ack_pulse", 16'(o_ltsm_ack), 16'd0);

        // LTSM and RDI in the same cycle
        ltsm(4'd5, 4'd2, 4'd9, 1'b0, 16'h1234);
        i_rdi_req = 1'b1;
        step();
        i_ltsm_req = 1'b0;
        i_rdi_req  = 1'b0;
        chk("s2_both_full", 16'({o_ltsm_ready, o_rdi_ready}), 16'd0);
        step();
        chk("s2_rdi_first", 16'(o_rdi_msg), 16'd1);
        chk("s2_rdi_dv", 16'(o_data_valid), 16'd0);
        chk("s2_rdi_fields", 16'({o_state, o_sub_state, o_msg_no}), 16'd0);
        i_enc_d_valid = 1'b1;
        step();
        step();
        i_enc_d_valid = 1'b0;
        i_tx_done = 1'b1;
        step();
        i_tx_done = 1'b0;
        chk("s2_rdi_ack", 16'({o_rdi_ack, o_ltsm_ack}), 16'b10);
        chk("s2_ready", 16'({o_rdi_ready, o_ltsm_ready}), 16'b10);
        step();
        chk("s2_ltsm_second", 16'({o_msg_valid, o_rdi_msg}), 16'b10);
        chk("s2_ltsm_fields", 16'({o_state, o_sub_state, o_msg_no}), 16'h529);
        i_enc_d_valid = 1'b1;
        step();
        step();
        i_enc_d_valid = 1'b0;
        i_tx_done = 1'b1;
        step();
        i_tx_done = 1'b0;
        chk("s2_ltsm_ack", 16'({o_rdi_ack, o_ltsm_ack}), 16'b01);

        // RDI always pending; LTSM offered once two RDI grants have gone by
        i_rdi_req = 1'b1;
        n = 0;
        since = 0;
        guard = 0;
        p_iss = 1'b0;
        p_enc = 1'b0;
        while (guard < 300 && !(n >= 6 && !o_busy && o_rdi_ready &&
                                o_ltsm_ready && !p_iss && !p_enc)) begin
            i_enc_d_valid = p_iss;
            i_tx_done = p_enc;
            p_enc = p_iss;
            p_iss = o_msg_valid;
            if (o_msg_valid) begin
                if (n < 8) grants[n] = o_rdi_msg;
                n++;
                since = o_rdi_msg ? since + 1 : 0;
            end
            i_rdi_req = (n < 6);
            i_ltsm_req = (since == 2) && o_ltsm_ready && o_rdi_ready && !o_busy;
            step();
            guard++;
        end
        i_rdi_req = 1'b0;
        i_ltsm_req = 1'b0;
        i_enc_d_valid = 1'b0;
        i_tx_done = 1'b0;
        chk("s3_bound", 16'(guard < 300), 16'd1);
        chk("s3_g0", 16'(grants[0]), 16'd1);
        chk("s3_g1", 16'(grants[1]), 16'd1);
        chk("s3_g2", 16'(grants[2]), 16'd0);
        chk("s3_g3", 16'(grants[3]), 16'd1);
        chk("s3_g4", 16'(grants[4]), 16'd1);
        chk("s3_g5", 16'(grants[5]), 16'd0);

        // encoder produces nothing -> drop
        ltsm(4'd1, 4'd1, 4'd0, 1'b1, 16'hBEEF);
        step();
        i_ltsm_req = 1'b0;
        step();
        chk("s4_issue", 16'(o_msg_valid), 16'd1);
        step();
        chk("s4_no_early_drop", 16'(o_drop), 16'd0);
        step();
        chk("s4_drop_ack", 16'({o_drop, o_ltsm_ack, o_timeout}), 16'b110);
        chk("s4_idle", 16'({o_busy, o_ltsm_ready}), 16'b01);
        step();
        chk("s4_drop_pulse", 16'(o_drop), 16'd0);

        // tx_done never arrives -> timeout after 8 WAIT_TX cycles
        ltsm(4'd2, 4'd3, 4'd4, 1'b0, 16'h0001);
        step();
        i_ltsm_req = 1'b0;
        step();
        i_enc_d_valid = 1'b1;
        step();
        step();
        i_enc_d_valid = 1'b0;
        for (int i = 0; i < 7; i++) step();
        chk("s5_no_early_tmo", 16'({o_timeout, o_busy}), 16'b01);
        step();
        chk("s5_timeout", 16'({o_timeout, o_ltsm_ack}), 16'b10);
        chk("s5_ready", 16'({o_ltsm_ready, o_busy}), 16'b10);
        step();
        chk("s5_tmo_pulse", 16'(o_timeout), 16'd0);

        // reset in WAIT_TX with an RDI also pending
        ltsm(4'd7, 4'd6, 4'd5, 1'b1, 16'hA5A5);
        step();
        i_ltsm_req = 1'b0;
        step();
        i_rdi_req = 1'b1;
        i_enc_d_valid = 1'b1;
        step();
        i_rdi_req = 1'b0;
        step();
        i_enc_d_valid = 1'b0;
        chk("s6_in_wait_tx", 16'({o_busy, o_rdi_ready}), 16'b10);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_rst_busy", 16'(o_busy), 16'd0);
        chk("s6_rst_ready", 16'({o_ltsm_ready, o_rdi_ready}), 16'b11);
        chk("s6_rst_fields", 16'({o_state, o_sub_state, o_msg_no}), 16'd0);
        chk("s6_rst_data", o_data_bus, 16'd0);
        i_tx_done = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        i_tx_done = 1'b1;
        i_rdi_req = 1'b1;
        ack_seen = 1'b0;
        step();
        ack_seen = ack_seen | o_ltsm_ack | o_rdi_ack;
        i_rdi_req = 1'b0;
        i_tx_done = 1'b0;
        chk("s6_first_accept", 16'(o_rdi_ready), 16'd0);
        chk("s6_ltsm_ready", 16'(o_ltsm_ready), 16'd1);
        step();
        ack_seen = ack_seen | o_ltsm_ack | o_rdi_ack;
        chk("s6_rdi_issue", 16'({o_msg_valid, o_rdi_msg}), 16'b11);
        step();
        ack_seen = ack_seen | o_ltsm_ack | o_rdi_ack;
        chk("s6_no_ack", 16'(ack_seen), 16'd0);
        step();
        chk("s6_rdi_drop", 16'({o_drop, o_rdi_ack, o_ltsm_ack}), 16'b110);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
